// File: rtl/alarm_clk_pkg.sv
// Shared types and constants for the alarm-clock timer master: FSM states,
// timer register map, control/status bit definitions and a time validity helper.
package alarm_clk_pkg;

   typedef enum logic [2:0] {
      INIT_WR,
      IDLE,
      CLR_WR,
      RD,
      CHK
   } state_t;

   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_CONTROL = 3'd1;
   localparam logic [2:0] ADDR_PERIODL = 3'd2;
   localparam logic [2:0] ADDR_PERIODH = 3'd3;

   localparam logic [15:0] CTRL_ITO = 16'h0001;

   localparam int TO  = 0;
   localparam int RUN = 1;

   // A time-of-day load is only honoured when it names a real hour and minute.
   function automatic logic timeValid(input logic [4:0] h, input logic [5:0] m);
      return (h <= 5'd23) && (m <= 6'd59);
   endfunction

endpackage

// File: rtl/alarm_clk_hms_counter.sv
// Hours/minutes/seconds time-of-day counter with load, carry chain and
// alarm compare; second and alarm pulses are registered one-cycle strobes.
import alarm_clk_pkg::*;

module alarm_clk_hms_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_secTick,
   input  logic       i_setLoad,
   input  logic [4:0] i_setHour,
   input  logic [5:0] i_setMin,
   input  logic       i_alarmEn,
   input  logic [4:0] i_alarmHour,
   input  logic [5:0] i_alarmMin,
   output logic [4:0] o_hour,
   output logic [5:0] o_min,
   output logic [5:0] o_sec,
   output logic       o_secondPulse,
   output logic       o_alarmHit
);

   logic [4:0] r_hour;
   logic [5:0] r_min;
   logic [5:0] r_sec;
   logic       r_secondPulse;
   logic       r_alarmHit;

   logic [4:0] w_nextHour;
   logic [5:0] w_nextMin;
   logic [5:0] w_nextSec;

   always_comb begin
      w_nextHour = r_hour;
      w_nextMin  = r_min;
      w_nextSec  = r_sec + 6'd1;
      if (r_sec == 6'd59) begin
         w_nextSec = 6'd0;
         if (r_min == 6'd59) begin
            w_nextMin  = 6'd0;
            w_nextHour = (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
         end else begin
            w_nextMin = r_min + 6'd1;
         end
      end
   end

   // A valid load overrides a coinciding tick, so neither pulse fires then.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hour        <= 5'd0;
         r_min         <= 6'd0;
         r_sec         <= 6'd0;
         r_secondPulse <= 1'b0;
         r_alarmHit    <= 1'b0;
      end else begin
         r_secondPulse <= 1'b0;
         r_alarmHit    <= 1'b0;
         if (i_setLoad) begin
            r_hour <= i_setHour;
            r_min  <= i_setMin;
            r_sec  <= 6'd0;
         end else if (i_secTick) begin
            r_hour        <= w_nextHour;
            r_min         <= w_nextMin;
            r_sec         <= w_nextSec;
            r_secondPulse <= 1'b1;
            r_alarmHit    <= i_alarmEn && (w_nextHour == i_alarmHour) &&
                             (w_nextMin == i_alarmMin) && (w_nextSec == 6'd0);
         end
      end
   end

   assign o_hour        = r_hour;
   assign o_min         = r_min;
   assign o_sec         = r_sec;
   assign o_secondPulse = r_secondPulse;
   assign o_alarmHit    = r_alarmHit;

endmodule

// File: rtl/alarm_clk_tick_master.sv
// Avalon-MM master servicing the interval timer: enables its IRQ, then on
// every IRQ clears/reads back status, counts ticks and keeps time of day.
import alarm_clk_pkg::*;

module alarm_clk_tick_master #(
   parameter int TICKS_PER_SEC = 10000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        irq,
   input  logic [15:0] readdata,
   output logic [2:0]  address,
   output logic        chipselect,
   output logic        write_n,
   output logic [15:0] writedata,
   input  logic        set_en,
   input  logic [4:0]  set_hour,
   input  logic [5:0]  set_min,
   input  logic        alarm_en,
   input  logic [4:0]  alarm_hour,
   input  logic [5:0]  alarm_min,
   output logic [4:0]  hour,
   output logic [5:0]  min,
   output logic [5:0]  sec,
   output logic        second_pulse,
   output logic        alarm_hit,
   output logic        err
);

   localparam logic [15:0] TICK_MAX = 16'(TICKS_PER_SEC - 1);

   state_t      r_state;
   logic [2:0]  r_address;
   logic        r_chipselect;
   logic        r_write_n;
   logic [15:0] r_writedata;
   logic        r_err;
   logic [15:0] r_tickCnt;

   logic w_tickAdv;
   logic w_secTick;
   logic w_setLoad;
   logic w_unusedRd;

   assign w_tickAdv  = (r_state == CLR_WR);
   assign w_secTick  = w_tickAdv && (r_tickCnt == TICK_MAX);
   assign w_setLoad  = set_en && timeValid(set_hour, set_min);
   assign w_unusedRd = ^readdata[15:2];

   // Bus outputs are loaded on the edge that enters a state, so each access
   // is on the bus for exactly the cycle the FSM spends in that state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= INIT_WR;
         r_address    <= ADDR_STATUS;
         r_chipselect <= 1'b0;
         r_write_n    <= 1'b1;
         r_writedata  <= 16'h0000;
         r_err        <= 1'b0;
      end else begin
         r_address    <= ADDR_STATUS;
         r_chipselect <= 1'b0;
         r_write_n    <= 1'b1;
         r_writedata  <= 16'h0000;
         case (r_state)
            INIT_WR: begin
               r_address    <= ADDR_CONTROL;
               r_chipselect <= 1'b1;
               r_write_n    <= 1'b0;
               r_writedata  <= CTRL_ITO;
               r_state      <= IDLE;
            end
            IDLE: begin
               if (irq) begin
                  r_chipselect <= 1'b1;
                  r_write_n    <= 1'b0;
                  r_state      <= CLR_WR;
               end
            end
            CLR_WR: begin
               r_chipselect <= 1'b1;
               r_state      <= RD;
            end
            RD: begin
               r_state <= CHK;
            end
            CHK: begin
               if (readdata[TO] || !readdata[RUN]) begin
                  r_err <= 1'b1;
               end
               r_state <= IDLE;
            end
            default: begin
               r_state <= INIT_WR;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tickCnt <= 16'd0;
      end else if (w_setLoad) begin
         r_tickCnt <= 16'd0;
      end else if (w_tickAdv) begin
         r_tickCnt <= w_secTick ? 16'd0 : r_tickCnt + 16'd1;
      end
   end

   alarm_clk_hms_counter u_hms (
      .clk           (clk),
      .reset         (reset),
      .i_secTick     (w_secTick),
      .i_setLoad     (w_setLoad),
      .i_setHour     (set_hour),
      .i_setMin      (set_min),
      .i_alarmEn     (alarm_en),
      .i_alarmHour   (alarm_hour),
      .i_alarmMin    (alarm_min),
      .o_hour        (hour),
      .o_min         (min),
      .o_sec         (sec),
      .o_secondPulse (second_pulse),
      .o_alarmHit    (alarm_hit)
   );

   assign address    = r_address;
   assign chipselect = r_chipselect;
   assign write_n    = r_write_n;
   assign writedata  = r_writedata;
   assign err        = r_err;

endmodule

// File: tb/tb_alarm_clk_tick_master.sv
// Directed bench for alarm_clk_tick_master with TICKS_PER_SEC=4; the bench
// plays the timer slave (irq, registered readdata) by hand at negedges.
module tb_alarm_clk_tick_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        irq;
   logic [15:0] readdata;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic        set_en;
   logic [4:0]  set_hour;
   logic [5:0]  set_min;
   logic        alarm_en;
   logic [4:0]  alarm_hour;
   logic [5:0]  alarm_min;
   logic [4:0]  hour;
   logic [5:0]  min;
   logic [5:0]  sec;
   logic        second_pulse;
   logic        alarm_hit;
   logic        err;

   int checks   = 0;
   int failures = 0;

   logic svcWrOk, svcRdOk, svcIdleOk, svcPulse, svcAlarm, svcAfter;
   int   pulseTotal, alarmTotal;

   always #5 clk = ~clk;

   alarm_clk_tick_master #(.TICKS_PER_SEC(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .irq          (irq),
      .readdata     (readdata),
      .address      (address),
      .chipselect   (chipselect),
      .write_n      (write_n),
      .writedata    (writedata),
      .set_en       (set_en),
      .set_hour     (set_hour),
      .set_min      (set_min),
      .alarm_en     (alarm_en),
      .alarm_hour   (alarm_hour),
      .alarm_min    (alarm_min),
      .hour         (hour),
      .min          (min),
      .sec          (sec),
      .second_pulse (second_pulse),
      .alarm_hit    (alarm_hit),
      .err          (err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One full IRQ service; called and returns at a negedge.
   task automatic applyStimulus(input logic [15:0] status, input logic doSet,
                                input logic [4:0] sh, input logic [5:0] sm);
      irq = 1'b1;
      @(negedge clk);
      svcWrOk = chipselect && !write_n && (address == 3'd0) && (writedata == 16'h0000);
      if (doSet) begin
         set_en   = 1'b1;
         set_hour = sh;
         set_min  = sm;
      end
      @(negedge clk);
      set_en   = 1'b0;
      svcRdOk  = chipselect && write_n && (address == 3'd0);
      svcPulse = second_pulse;
      svcAlarm = alarm_hit;
      readdata = status;
      @(negedge clk);
      irq       = 1'b0;
      svcIdleOk = !chipselect && write_n;
      svcAfter  = second_pulse || alarm_hit;
      @(negedge clk);
   endtask

   task automatic runTicks(input int n);
      pulseTotal = 0;
      alarmTotal = 0;
      for (int i = 0; i < n; i++) begin
         applyStimulus(16'h0002, 1'b0, 5'd0, 6'd0);
         pulseTotal += int'(svcPulse);
         alarmTotal += int'(svcAlarm);
      end
   endtask

   task automatic loadTime(input logic [4:0] h, input logic [5:0] m);
      set_en   = 1'b1;
      set_hour = h;
      set_min  = m;
      @(negedge clk);
      set_en = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; irq = 1'b0; readdata = 16'h0000;
      set_en = 1'b0; set_hour = 5'd0; set_min = 6'd0;
      alarm_en = 1'b0; alarm_hour = 5'd0; alarm_min = 6'd0;
      repeat (3) @(negedge clk);
      checkOutput("rst_cs", 32'(chipselect), 32'd0);
      checkOutput("rst_wn", 32'(write_n), 32'd1);
      checkOutput("rst_addr", 32'(address), 32'd0);
      checkOutput("rst_wd", 32'(writedata), 32'd0);
      checkOutput("rst_time", {11'd0, hour, min, 4'd0, sec}, 32'd0);
      checkOutput("rst_flags", {29'd0, second_pulse, alarm_hit, err}, 32'd0);

      reset = 1'b0;
      @(negedge clk);
      checkOutput("init_wr", {12'd0, address, chipselect, write_n, writedata}, {12'd0, 3'd1, 1'b1, 1'b0, 16'h0001});
      @(negedge clk);
      checkOutput("init_idle", {30'd0, chipselect, write_n}, 32'd1);
      repeat (3) @(negedge clk);
      checkOutput("idle_hold", {30'd0, chipselect, write_n}, 32'd1);

      applyStimulus(16'h0002, 1'b0, 5'd0, 6'd0);
      checkOutput("svc_wr_n1", 32'(svcWrOk), 32'd1);
      checkOutput("svc_rd_n2", 32'(svcRdOk), 32'd1);
      checkOutput("svc_idle_n3", 32'(svcIdleOk), 32'd1);
      checkOutput("svc_err", 32'(err), 32'd0);
      checkOutput("svc_no_pulse", 32'(svcPulse), 32'd0);
      @(negedge clk);
      checkOutput("svc_back_idle", {30'd0, chipselect, write_n}, 32'd1);

      runTicks(3);
      checkOutput("one_sec_pulses", 32'(pulseTotal), 32'd1);
      checkOutput("one_sec_sec", 32'(sec), 32'd1);
      checkOutput("one_sec_after", 32'(svcAfter), 32'd0);

      loadTime(5'd23, 6'd59);
      checkOutput("set_2359", {11'd0, hour, min, 4'd0, sec}, {11'd0, 5'd23, 6'd59, 4'd0, 6'd0});
      runTicks(59 * 4);
      checkOutput("at_235959", {11'd0, hour, min, 4'd0, sec}, {11'd0, 5'd23, 6'd59, 4'd0, 6'd59});
      runTicks(4);
      checkOutput("midnight", {11'd0, hour, min, 4'd0, sec}, 32'd0);
      checkOutput("midnight_pulse", 32'(pulseTotal), 32'd1);

      runTicks(3);
      applyStimulus(16'h0002, 1'b1, 5'd10, 6'd30);
      checkOutput("set_vs_tick_pulse", {30'd0, svcPulse, svcAlarm}, 32'd0);
      checkOutput("set_vs_tick_time", {11'd0, hour, min, 4'd0, sec}, {11'd0, 5'd10, 6'd30, 4'd0, 6'd0});
      runTicks(3);
      checkOutput("tick_cleared_3", 32'(pulseTotal), 32'd0);
      runTicks(1);
      checkOutput("tick_cleared_4", {31'd0, svcPulse}, 32'd1);

      alarm_en = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd0;
      loadTime(5'd6, 6'd59);
      runTicks(59 * 4);
      checkOutput("alarm_early", 32'(alarmTotal), 32'd0);
      runTicks(4);
      checkOutput("alarm_hit", {30'd0, svcPulse, svcAlarm}, 32'd3);
      checkOutput("alarm_one_cycle", 32'(svcAfter), 32'd0);
      checkOutput("alarm_time", {11'd0, hour, min, 4'd0, sec}, {11'd0, 5'd7, 6'd0, 4'd0, 6'd0});

      alarm_en = 1'b0;
      loadTime(5'd6, 6'd59);
      runTicks(60 * 4);
      checkOutput("alarm_dis", 32'(alarmTotal), 32'd0);
      checkOutput("alarm_dis_time", {11'd0, hour, min, 4'd0, sec}, {11'd0, 5'd7, 6'd0, 4'd0, 6'd0});

      loadTime(5'd24, 6'd10);
      checkOutput("bad_hour", {11'd0, hour, min, 4'd0, sec}, {11'd0, 5'd7, 6'd0, 4'd0, 6'd0});
      loadTime(5'd12, 6'd60);
      checkOutput("bad_min", {11'd0, hour, min, 4'd0, sec}, {11'd0, 5'd7, 6'd0, 4'd0, 6'd0});

      applyStimulus(16'h0003, 1'b0, 5'd0, 6'd0);
      checkOutput("err_set", 32'(err), 32'd1);
      applyStimulus(16'h0002, 1'b0, 5'd0, 6'd0);
      checkOutput("err_sticky", 32'(err), 32'd1);

      irq = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkOutput("pre_rst_rd", {30'd0, chipselect, write_n}, 32'd3);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst_abort_cs", 32'(chipselect), 32'd0);
      checkOutput("rst_clears_err", 32'(err), 32'd0);
      irq = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reinit_wr", {12'd0, address, chipselect, write_n, writedata}, {12'd0, 3'd1, 1'b1, 1'b0, 16'h0001});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
